// File: rtl/fp_mult_pipe_pkg.sv
// Shared types and helpers for the floating-point datapath: operand classes,
// flag bit positions, exponent bias and canonical quiet-NaN encoding.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int FLAGS_W  = 3;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Returned wide; callers size-cast to their own word width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe. The producer/consumer side
// uses the master modport, the multiplier uses slave.
interface fp_mult_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] in_tag;
  logic             rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     x;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       flags;

  modport master (
    output in_valid, a, b, in_tag, rnd_mode, out_ready,
    input  in_ready, out_valid, x, out_tag, flags
  );

  modport slave (
    input  in_valid, a, b, in_tag, rnd_mode, out_ready,
    output in_ready, out_valid, x, out_tag, flags
  );

endinterface

// File: rtl/fp_round.sv
// Combinational normalise-and-round of a raw significand product:
// one-bit normalise, guard/sticky extraction, RNE or RTZ, carry-out fix-up.
module fp_round #(
  parameter int MAN_W = 10,
  parameter int EXP_W = 5
) (
  input  logic [2*MAN_W+1:0]      prod,
  input  logic signed [EXP_W+1:0] esum_in,
  input  logic                    rnd_mode,
  output logic [MAN_W-1:0]        man,
  output logic signed [EXP_W+1:0] esum_out
);
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] ONE_S = EW'(1);

  logic [PW-1:0]          norm;
  logic signed [EW-1:0]   esum_n;
  logic [MAN_W-1:0]       man_t;
  logic                   g;
  logic                   s;
  logic                   inc;
  logic                   carry;
  logic [MAN_W-1:0]       man_r;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    norm   = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    esum_n = prod[PW-1] ? esum_in + ONE_S : esum_in;
    // Leading one now sits at PW-1; the stored mantissa is the MAN_W bits below it.
    man_t  = norm[PW-2 -: MAN_W];
    g      = norm[PW-2-MAN_W];
    s      = |norm[PW-3-MAN_W:0];
    inc    = ~rnd_mode & g & (s | man_t[0]);
    {carry, man_r} = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    man      = man_r;
    esum_out = carry ? esum_n + ONE_S : esum_n;
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754-style multiplier: classify/multiply, normalise/round, pack.
// All stages advance together whenever the output register is free or being drained.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst,
  fp_mult_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);

  localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_S   = '0;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [EXP_W-1:0]     EXP_FMAX = EXP_ONES - 1'b1;
  localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    fp_class_e c;
    if (e == '0)            c = FP_ZERO;  // subnormals flush to zero
    else if (e != EXP_ONES) c = FP_NORM;
    else if (m == '0)       c = FP_INF;
    else                    c = FP_NAN;
    return c;
  endfunction

  logic en;

  // Stage 1 registers
  logic                 s1_valid;
  logic                 s1_sign;
  fp_class_e            s1_cls_a, s1_cls_b;
  logic signed [EW-1:0] s1_esum;
  logic [PW-1:0]        s1_prod;
  logic [TAG_W-1:0]     s1_tag;
  logic                 s1_rnd;

  // Stage 2 registers
  logic                 s2_valid;
  logic                 s2_sign;
  fp_class_e            s2_cls_a, s2_cls_b;
  logic signed [EW-1:0] s2_esum;
  logic [MAN_W-1:0]     s2_man;
  logic [TAG_W-1:0]     s2_tag;
  logic                 s2_rnd;

  // Output registers
  logic                 out_valid_q;
  logic [W-1:0]         x_q;
  logic [TAG_W-1:0]     out_tag_q;
  logic [FLAGS_W-1:0]   flags_q;

  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     ma, mb;
  logic signed [EW-1:0] esum_c;
  logic [MAN_W-1:0]     r_man;
  logic signed [EW-1:0] r_esum;
  logic [W-1:0]         px;
  logic [FLAGS_W-1:0]   pf;
  logic                 any_nan, any_inf, any_zero;

  assign en            = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.flags     = flags_q;

  assign ea     = bus.a[W-2 -: EXP_W];
  assign eb     = bus.b[W-2 -: EXP_W];
  assign ma     = bus.a[MAN_W-1:0];
  assign mb     = bus.b[MAN_W-1:0];
  assign esum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
    end
  end

  // NOTE: datapath registers carry no reset; the stage valids alone qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign  <= bus.a[W-1] ^ bus.b[W-1];
      s1_cls_a <= classify(ea, ma);
      s1_cls_b <= classify(eb, mb);
      s1_esum  <= esum_c;
      s1_prod  <= PW'({1'b1, ma}) * PW'({1'b1, mb});
      s1_tag   <= bus.in_tag;
      s1_rnd   <= bus.rnd_mode;
    end
  end

  fp_round #(
    .MAN_W (MAN_W),
    .EXP_W (EXP_W)
  ) u_round (
    .prod     (s1_prod),
    .esum_in  (s1_esum),
    .rnd_mode (s1_rnd),
    .man      (r_man),
    .esum_out (r_esum)
  );

  always_ff @(posedge clk) begin
    if (en) begin
      s2_sign  <= s1_sign;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_esum  <= r_esum;
      s2_man   <= r_man;
      s2_tag   <= s1_tag;
      s2_rnd   <= s1_rnd;
    end
  end

  always_comb begin
    px       = '0;
    pf       = '0;
    any_nan  = (s2_cls_a == FP_NAN) || (s2_cls_b == FP_NAN);
    any_inf  = (s2_cls_a == FP_INF) || (s2_cls_b == FP_INF);
    any_zero = (s2_cls_a == FP_ZERO) || (s2_cls_b == FP_ZERO);
    if (any_nan || (any_inf && any_zero)) begin
      px           = QNAN;
      pf[FLAG_INV] = 1'b1;
    end else if (any_inf) begin
      px = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      px = {s2_sign, {(W-1){1'b0}}};
    end else if (s2_esum >= EXP_MAX) begin
      // RTZ saturates to the largest finite value instead of infinity.
      pf[FLAG_OVF] = 1'b1;
      px = s2_rnd ? {s2_sign, EXP_FMAX, {MAN_W{1'b1}}}
                  : {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_esum <= ZERO_S) begin
      pf[FLAG_UNF] = 1'b1;
      px = {s2_sign, {(W-1){1'b0}}};
    end else begin
      px = {s2_sign, s2_esum[EXP_W-1:0], s2_man};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      out_tag_q   <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        x_q       <= px;
        out_tag_q <= s2_tag;
        flags_q   <= pf;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (fp16): directed corner cases, backpressure,
// mid-flight reset and randomized traffic scored against a real-arithmetic model.
module tb_fp_mult_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [15:0] x;
    logic [3:0]  tag;
    logic [2:0]  flags;
  } result_t;

  logic clk = 1'b0;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;
  result_t exp_q[$];
  logic [3:0] next_tag = 4'd0;

  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, expv);
    end
  endtask

  // Reference: exact significand product in real arithmetic, then IEEE-style rounding.
  function automatic result_t ref_mul(input logic [15:0] a, input logic [15:0] b,
                                      input logic rnd, input logic [3:0] tag);
    result_t r;
    int ea, eb, ma, mb, e, man;
    logic sign;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    real m, f, fl, rem;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    sign   = a[15] ^ b[15];
    a_zero = (ea == 0);  b_zero = (eb == 0);
    a_inf  = (ea == 31) && (ma == 0);
    b_inf  = (eb == 31) && (mb == 0);
    a_nan  = (ea == 31) && (ma != 0);
    b_nan  = (eb == 31) && (mb != 0);
    r.tag   = tag;
    r.flags = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r.x = 16'h7E00; r.flags = 3'b100;
    end else if (a_inf || b_inf) begin
      r.x = {sign, 5'h1F, 10'h000};
    end else if (a_zero || b_zero) begin
      r.x = {sign, 15'h0000};
    end else begin
      m = (1.0 + ma / 1024.0) * (1.0 + mb / 1024.0);
      e = ea + eb - 15;
      if (m >= 2.0) begin m = m / 2.0; e++; end
      f   = (m - 1.0) * 1024.0;
      fl  = $floor(f);
      rem = f - fl;
      man = int'(fl);
      if (!rnd && (rem > 0.5 || (rem == 0.5 && (man % 2) == 1))) man++;
      if (man == 1024) begin man = 0; e++; end
      if (e >= 31) begin
        r.flags = 3'b010;
        r.x = rnd ? {sign, 5'h1E, 10'h3FF} : {sign, 5'h1F, 10'h000};
      end else if (e <= 0) begin
        r.flags = 3'b001;
        r.x = {sign, 15'h0000};
      end else begin
        r.x = {sign, 5'(e), 10'(man)};
      end
    end
    return r;
  endfunction

  // Presents one operand pair; queues its expected result on the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rnd,
                      input result_t expv);
    int waited = 0;
    bus.a = a; bus.b = b; bus.rnd_mode = rnd; bus.in_tag = expv.tag; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    else exp_q.push_back(expv);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    next_tag = next_tag + 4'd1;
  endtask

  task automatic send_dir(input logic [15:0] a, input logic [15:0] b, input logic rnd,
                          input logic [15:0] ex, input logic [2:0] ef);
    result_t r;
    r.x = ex; r.tag = next_tag; r.flags = ef;
    send(a, b, rnd, r);
  endtask

  task automatic send_ref(input logic [15:0] a, input logic [15:0] b, input logic rnd);
    send(a, b, rnd, ref_mul(a, b, rnd, next_tag));
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 200) check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_operand();
    logic [4:0] e;
    case ($urandom_range(0, 9))
      0:       e = 5'd0;
      1:       e = 5'd31;
      2:       e = 5'($urandom_range(1, 4));
      3:       e = 5'($urandom_range(27, 30));
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
  endfunction

  // Scoreboard: every delivered result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    result_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_x",     32'(bus.x),       32'(e.x));
        check("result_tag",   32'(bus.out_tag), 32'(e.tag));
        check("result_flags", 32'(bus.flags),   32'(e.flags));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    result_t held;
    logic [15:0] ra, rb;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.in_tag = '0;
    bus.rnd_mode = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_x",         32'(bus.x),         32'd0);
    check("rst_out_tag",   32'(bus.out_tag),   32'd0);
    check("rst_flags",     32'(bus.flags),     32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: result appears on the third edge counting the accepting one
    send_dir(16'h3E00, 16'h4000, 1'b0, 16'h4200, 3'b000);
    check("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_edge3_x",     32'(bus.x),         32'h4200);
    drain();

    // Directed values, back to back
    send_dir(16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 3'b000);
    send_dir(16'hC000, 16'h4000, 1'b0, 16'hC400, 3'b000);
    send_dir(16'h8000, 16'h3C00, 1'b0, 16'h8000, 3'b000);
    send_dir(16'h3C01, 16'h3C01, 1'b0, 16'h3C02, 3'b000);
    send_dir(16'h3BFF, 16'h3C01, 1'b0, 16'h3C00, 3'b000);
    send_dir(16'h3BFF, 16'h3C01, 1'b1, 16'h3C00, 3'b000);
    send_dir(16'h3E00, 16'h3C01, 1'b0, 16'h3E02, 3'b000);
    send_dir(16'h3E00, 16'h3C01, 1'b1, 16'h3E01, 3'b000);
    send_dir(16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 3'b010);
    send_dir(16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 3'b010);
    send_dir(16'h7C00, 16'h0000, 1'b0, 16'h7E00, 3'b100);
    send_dir(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b100);
    send_dir(16'h0400, 16'h0400, 1'b0, 16'h0000, 3'b001);
    send_dir(16'h0001, 16'h3C00, 1'b0, 16'h0000, 3'b000);
    send_dir(16'h7C00, 16'hC000, 1'b0, 16'hFC00, 3'b000);
    drain();

    // Backpressure: three issued, consumer stalls, two more offered during the stall
    next_tag = 4'd0;
    send_ref(16'h3C00, 16'h4000, 1'b0);
    send_ref(16'h4200, 16'h3E00, 1'b0);
    send_ref(16'hBC00, 16'h4400, 1'b0);
    bus.out_ready = 1'b0;
    held = exp_q[0];
    bus.a = 16'h4500; bus.b = 16'h3555; bus.rnd_mode = 1'b0;
    bus.in_tag = next_tag; bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready",  32'(bus.in_ready),  32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_x_held",    32'(bus.x),         32'(held.x));
      check("stall_tag_held",  32'(bus.out_tag),   32'(held.tag));
      check("stall_flags_held",32'(bus.flags),     32'(held.flags));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_ref(16'h4500, 16'h3555, 1'b0);
    send_ref(16'h5640, 16'hC123, 1'b0);
    drain();

    // Reset with three operations in flight
    bus.out_ready = 1'b0;
    send_ref(16'h3C00, 16'h3C00, 1'b0);
    send_ref(16'h4000, 16'h4000, 1'b0);
    send_ref(16'h4400, 16'h4400, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_x",         32'(bus.x),         32'd0);
    check("midrst_out_tag",   32'(bus.out_tag),   32'd0);
    check("midrst_flags",     32'(bus.flags),     32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with occasional idle cycles and consumer stalls
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      ra = rand_operand();
      rb = rand_operand();
      send_ref(ra, rb, 1'($urandom_range(0, 1)));
    end
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
